// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS decode stage (control, regfile, sign extend, ID/EX register, load-use stall).
// Define ID_WB_BYPASS_EN to make same-cycle write-back data visible on the read ports.
module id_stage_hz #(
   parameter int DATA_W = 32,
   parameter int NREGS = 32,
   localparam int RA_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       if_id_instr,
   input  logic [DATA_W-1:0] if_id_npc,
   input  logic              if_id_valid,
   input  logic              wb_reg_write,
   input  logic [RA_W-1:0]   wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              stall,
   output logic              id_ex_valid,
   output logic [1:0]        wb_ctl_out,
   output logic [2:0]        m_ctl_out,
   output logic              reg_dst,
   output logic              alu_src,
   output logic [1:0]        alu_op,
   output logic [DATA_W-1:0] npc_out,
   output logic [DATA_W-1:0] r_data1_out,
   output logic [DATA_W-1:0] r_data2_out,
   output logic [DATA_W-1:0] sign_extend_out,
   output logic [RA_W-1:0]   instr_rt_out,
   output logic [RA_W-1:0]   instr_rd_out
);
   localparam logic [RA_W:0] NR = (RA_W+1)'(NREGS);
   logic [5:0]        op;
   logic [RA_W-1:0]   rs, rt, rd;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] rf1, rf2, rd1, rd2, sx;
   logic              we, haz, bubble, valid_d, valid_q;
   logic [8:0]        dec, ctl_d, ctl_q;
   logic [DATA_W-1:0] npc_q, r1_q, r2_q, sx_q;
   logic [RA_W-1:0]   rt_q, rd_q;
   assign op = if_id_instr[31:26];
   assign rs = if_id_instr[21+RA_W-1:21];
   assign rt = if_id_instr[16+RA_W-1:16];
   assign rd = if_id_instr[11+RA_W-1:11];
   assign sx = DATA_W'($signed(if_id_instr[15:0]));
   assign we = wb_reg_write && wb_rd != '0 && {1'b0, wb_rd} < NR;
   assign rf1 = (rs != '0 && {1'b0, rs} < NR) ? regs_q[rs] : '0;
   assign rf2 = (rt != '0 && {1'b0, rt} < NR) ? regs_q[rt] : '0;
`ifdef ID_WB_BYPASS_EN
   assign rd1 = (we && wb_rd == rs) ? wb_data : rf1;
   assign rd2 = (we && wb_rd == rt) ? wb_data : rf2;
`else
   assign rd1 = rf1;
   assign rd2 = rf2;
`endif
   // {reg_dst, alu_src, alu_op[1:0], branch, mem_read, mem_write, reg_write, mem_to_reg}
   assign dec = (op == 6'h00) ? 9'b1_0_10_000_10 :
                (op == 6'h23) ? 9'b0_1_00_010_11 :
                (op == 6'h2B) ? 9'b0_1_00_001_00 :
                (op == 6'h04) ? 9'b0_0_01_100_00 : 9'b0;
   assign haz = valid_q && ctl_q[3] && rt_q != '0 && if_id_valid && (rt_q == rs || rt_q == rt);
   assign stall = haz && !flush;
   assign bubble = flush || haz;
   assign valid_d = !bubble && if_id_valid;
   assign ctl_d = valid_d ? dec : 9'b0;
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we) begin
         regs_q[wb_rd] <= wb_data;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctl_q   <= '0;
         npc_q   <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         sx_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctl_q   <= ctl_d;
         npc_q   <= if_id_npc;
         r1_q    <= rd1;
         r2_q    <= rd2;
         sx_q    <= sx;
         rt_q    <= rt;
         rd_q    <= rd;
      end
   end
   assign id_ex_valid     = valid_q;
   assign reg_dst         = ctl_q[8];
   assign alu_src         = ctl_q[7];
   assign alu_op          = ctl_q[6:5];
   assign m_ctl_out       = ctl_q[4:2];
   assign wb_ctl_out      = ctl_q[1:0];
   assign npc_out         = npc_q;
   assign r_data1_out     = r1_q;
   assign r_data2_out     = r2_q;
   assign sign_extend_out = sx_q;
   assign instr_rt_out    = rt_q;
   assign instr_rd_out    = rd_q;
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed checks of id_stage_hz at default size and at DATA_W=64, NREGS=16.
module tb_id_stage_hz;
   logic clk = 1'b0, rst;
   always #5 clk = ~clk;
   logic [31:0] a_instr, a_npc, a_wdat;
   logic        a_valid, a_wre, a_flush;
   logic [4:0]  a_wrd;
   logic        a_stall, a_v, a_rdst, a_asrc;
   logic [1:0]  a_wb, a_aop;
   logic [2:0]  a_m;
   logic [31:0] a_npco, a_r1, a_r2, a_sx;
   logic [4:0]  a_rt, a_rd;
   logic [31:0] b_instr;
   logic [63:0] b_npc, b_wdat;
   logic        b_valid, b_wre;
   logic [3:0]  b_wrd;
   logic        b_stall, b_v, b_rdst, b_asrc;
   logic [1:0]  b_wb, b_aop;
   logic [2:0]  b_m;
   logic [63:0] b_npco, b_r1, b_r2, b_sx;
   logic [3:0]  b_rt, b_rd;
   int total = 0, bad = 0;
`ifdef ID_WB_BYPASS_EN
   localparam logic [31:0] EXP7 = 32'h1234;
`else
   localparam logic [31:0] EXP7 = 32'h1111;
`endif
   id_stage_hz dut_a (
      .clk(clk), .rst(rst), .if_id_instr(a_instr), .if_id_npc(a_npc), .if_id_valid(a_valid),
      .wb_reg_write(a_wre), .wb_rd(a_wrd), .wb_data(a_wdat), .flush(a_flush), .stall(a_stall),
      .id_ex_valid(a_v), .wb_ctl_out(a_wb), .m_ctl_out(a_m), .reg_dst(a_rdst), .alu_src(a_asrc),
      .alu_op(a_aop), .npc_out(a_npco), .r_data1_out(a_r1), .r_data2_out(a_r2),
      .sign_extend_out(a_sx), .instr_rt_out(a_rt), .instr_rd_out(a_rd));
   id_stage_hz #(.DATA_W(64), .NREGS(16)) dut_b (
      .clk(clk), .rst(rst), .if_id_instr(b_instr), .if_id_npc(b_npc), .if_id_valid(b_valid),
      .wb_reg_write(b_wre), .wb_rd(b_wrd), .wb_data(b_wdat), .flush(1'b0), .stall(b_stall),
      .id_ex_valid(b_v), .wb_ctl_out(b_wb), .m_ctl_out(b_m), .reg_dst(b_rdst), .alu_src(b_asrc),
      .alu_op(b_aop), .npc_out(b_npco), .r_data1_out(b_r1), .r_data2_out(b_r2),
      .sign_extend_out(b_sx), .instr_rt_out(b_rt), .instr_rd_out(b_rd));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   function automatic logic [8:0] actl();
      return {a_rdst, a_asrc, a_aop, a_m, a_wb};
   endfunction
   initial begin
      rst = 1'b1;
      a_instr = '0; a_npc = '0; a_valid = 1'b0; a_wre = 1'b0; a_wrd = '0; a_wdat = '0; a_flush = 1'b0;
      b_instr = '0; b_npc = '0; b_valid = 1'b0; b_wre = 1'b0; b_wrd = '0; b_wdat = '0;
      tick;
      tick;
      chk("rst_valid", a_v, 0);
      chk("rst_ctl", actl(), 0);
      chk("rst_data", {a_npco, a_r1, a_r2, a_sx} == '0, 1);
      chk("rst_fields", {a_rt, a_rd}, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_b_valid", b_v, 0);
      rst = 1'b0;
      b_wre = 1'b1; b_wrd = 4'hF; b_wdat = 64'h0123_4567_89AB_CDEF;
      tick;
      b_wre = 1'b0; b_instr = 32'h01F3_8000; b_valid = 1'b1;
      tick;
      chk("b_sext", b_sx, 64'hFFFF_FFFF_FFFF_8000);
      chk("b_r15", b_r1, 64'h0123_4567_89AB_CDEF);
      chk("b_rs13", b_r2, 0);
      chk("b_rt_field", b_rt, 4'h3);
      chk("b_valid", b_v, 1);
      b_valid = 1'b0;
      for (int i = 1; i < 32; i++) begin
         logic [4:0] r;
         r = 5'(i);
         a_instr = {6'h00, r, r, 16'h0};
         a_valid = 1'b1;
         tick;
         chk("rf_zero", {a_r1, a_r2}, 0);
      end
      a_valid = 1'b0; a_wre = 1'b1; a_wrd = 5'd5; a_wdat = 32'hDEAD_BEEF;
      tick;
      a_wre = 1'b0; a_instr = 32'h00A5_1820; a_npc = 32'h104; a_valid = 1'b1;
      tick;
      chk("add_r1", a_r1, 32'hDEAD_BEEF);
      chk("add_r2", a_r2, 32'hDEAD_BEEF);
      chk("add_ctl", actl(), 9'b1_0_10_000_10);
      chk("add_valid", a_v, 1);
      chk("add_npc", a_npco, 32'h104);
      chk("add_rd", a_rd, 3);
      a_instr = 32'h8C08_FFFC; a_npc = 32'h108;
      #1 chk("lw_nostall", a_stall, 0);
      tick;
      chk("lw_sext", a_sx, 32'hFFFF_FFFC);
      chk("lw_ctl", actl(), 9'b0_1_00_010_11);
      chk("lw_rt", a_rt, 8);
      a_instr = 32'h0100_4820; a_wre = 1'b1; a_wrd = 5'd10; a_wdat = 32'hA5A5;
      #1 chk("haz_stall", a_stall, 1);
      tick;
      chk("haz_bubble_v", a_v, 0);
      chk("haz_bubble_ctl", actl(), 0);
      a_wre = 1'b0;
      #1 chk("haz_release", a_stall, 0);
      tick;
      chk("add2_valid", a_v, 1);
      chk("add2_rd", a_rd, 9);
      chk("add2_ctl", actl(), 9'b1_0_10_000_10);
      a_instr = 32'h0140_0820;
      tick;
      chk("wb_in_stall", a_r1, 32'hA5A5);
      a_instr = 32'h8C08_FFFC;
      tick;
      a_instr = 32'h0100_4820; a_flush = 1'b1;
      #1 chk("flush_nostall", a_stall, 0);
      tick;
      chk("flush_v", a_v, 0);
      chk("flush_ctl", actl(), 0);
      a_flush = 1'b0; a_instr = 32'hAC08_0004;
      tick;
      chk("sw_ctl", actl(), 9'b0_1_00_001_00);
      a_instr = 32'h1108_0003;
      tick;
      chk("beq_ctl", actl(), 9'b0_0_01_100_00);
      a_instr = 32'h2000_0010;
      tick;
      chk("nop_valid", a_v, 1);
      chk("nop_ctl", actl(), 0);
      a_instr = 32'h00A5_1820; a_valid = 1'b0;
      tick;
      chk("inv_valid", a_v, 0);
      chk("inv_ctl", actl(), 0);
      a_wre = 1'b1; a_wrd = 5'd7; a_wdat = 32'h1111;
      tick;
      a_wdat = 32'h1234; a_instr = 32'h00E7_0820; a_valid = 1'b1;
      tick;
      chk("r7_same_cycle", a_r1, EXP7);
      a_wre = 1'b0;
      tick;
      chk("r7_next", {a_r1, a_r2}, {32'h1234, 32'h1234});
      a_wre = 1'b1; a_wrd = 5'd0; a_wdat = 32'hFFFF; a_instr = 32'h0000_0820;
      tick;
      chk("r0_same", a_r1, 0);
      a_wre = 1'b0;
      tick;
      chk("r0_next", a_r1, 0);
      a_instr = 32'h8C08_FFFC;
      tick;
      a_instr = 32'h0100_4820;
      #1 chk("rst_haz_stall", a_stall, 1);
      rst = 1'b1;
      tick;
      chk("rst_mid_v", a_v, 0);
      chk("rst_mid_stall", a_stall, 0);
      rst = 1'b0; a_instr = 32'h00A5_1820;
      tick;
      chk("rst_cleared_r5", a_r1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
